// File: rtl/spi_regbank_if.sv
// Byte-level SPI slave handshake between the SPI shifter and spi_regbank.
interface spi_regbank_if;
  logic       frame_active;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;

  modport master (output frame_active, rx_valid, rx_byte, input tx_byte);
  modport slave  (input frame_active, rx_valid, rx_byte, output tx_byte);
endinterface

// File: rtl/spi_regbank.sv
// SPI command parser and register bank feeding the graph display (bars/strs).
// Optional SPI_REGBANK_SHADOW_EN: writes land in shadows, committed at frame end.
module spi_regbank #(
  parameter logic [7:0] ID_VALUE   = 8'hA5,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic          CLK,
  input  logic          RESET_N,
  spi_regbank_if.slave  spi,
  input  logic [31:0]   tasty_in,
  input  logic [7:0]    count_in,
  output logic [63:0]   bars,
  output logic [255:0]  strs,
  output logic          frame_err
);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, WAIT_END} state_t;

  state_t r_state, w_nxt;

  logic [7:0][7:0]  r_bars;
  logic [31:0][7:0] r_chr;
  logic [7:0][7:0]  w_src_bars;
  logic [31:0][7:0] w_src_chr;
  logic [6:0]       r_addr, w_addr_inc, w_rd_addr;
  logic [7:0]       r_tx, w_rd_data;
  logic             r_got, r_err;
  logic             w_wr_en, w_tx_ld, w_addr_ld, w_inc, w_set_err, w_frame_end;

  assign w_addr_inc = (r_addr == 7'h3F) ? 7'h00 : r_addr + 7'd1;

  always_ff @(posedge CLK) begin
    if (!RESET_N) r_state <= spi.frame_active ? WAIT_END : IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt       = r_state;
    w_wr_en     = 1'b0;
    w_tx_ld     = 1'b0;
    w_addr_ld   = 1'b0;
    w_inc       = 1'b0;
    w_set_err   = 1'b0;
    w_frame_end = 1'b0;
    w_rd_addr   = w_addr_inc;
    case (r_state)
      IDLE: if (spi.frame_active) w_nxt = CMD;
      CMD: begin
        if (!spi.frame_active) begin
          w_nxt       = IDLE;
          w_frame_end = 1'b1;
        end else if (spi.rx_valid) begin
          w_addr_ld = 1'b1;
          if (spi.rx_byte[7]) begin
            w_tx_ld   = 1'b1;
            w_rd_addr = spi.rx_byte[6:0];
            w_nxt     = READ;
          end else begin
            w_nxt = WRITE;
          end
        end
      end
      WRITE, READ: begin
        // A frame carrying only the command byte is flagged as malformed
        if (!spi.frame_active) begin
          w_nxt       = IDLE;
          w_frame_end = 1'b1;
          w_set_err   = !r_got;
        end else if (spi.rx_valid) begin
          w_inc   = 1'b1;
          w_wr_en = (r_state == WRITE);
          w_tx_ld = (r_state == READ);
        end
      end
      WAIT_END: if (!spi.frame_active) w_nxt = IDLE;
      default:  w_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_rd_data = 8'h00;
    if (w_rd_addr < 7'h08)
      w_rd_data = w_src_bars[w_rd_addr[2:0]];
    else if (w_rd_addr >= 7'h10 && w_rd_addr <= 7'h2F)
      w_rd_data = w_src_chr[w_rd_addr[4:0] - 5'h10];
    else if (w_rd_addr >= 7'h30 && w_rd_addr <= 7'h33)
      w_rd_data = tasty_in[8*(3 - w_rd_addr[1:0]) +: 8];
    else if (w_rd_addr == 7'h34)
      w_rd_data = count_in;
    else if (w_rd_addr == 7'h3F)
      w_rd_data = ID_VALUE;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_addr <= 7'h00;
      r_got  <= 1'b0;
      r_tx   <= 8'h00;
      r_err  <= 1'b0;
    end else begin
      if (w_addr_ld) begin
        r_addr <= spi.rx_byte[6:0];
        r_got  <= 1'b0;
      end else if (w_inc) begin
        r_addr <= w_addr_inc;
        r_got  <= 1'b1;
      end
      if (w_tx_ld) r_tx <= w_rd_data;
      if (w_set_err)                           r_err <= 1'b1;
      else if (w_wr_en && r_addr == 7'h3E)     r_err <= 1'b0;
    end
  end

`ifdef SPI_REGBANK_SHADOW_EN
  logic [7:0][7:0]  r_sh_bars;
  logic [31:0][7:0] r_sh_chr;

  assign w_src_bars = r_sh_bars;
  assign w_src_chr  = r_sh_chr;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_sh_bars <= '0;
      r_sh_chr  <= {32{BLANK_CHAR}};
      r_bars    <= '0;
      r_chr     <= {32{BLANK_CHAR}};
    end else begin
      if (w_wr_en && r_addr < 7'h08)
        r_sh_bars[r_addr[2:0]] <= spi.rx_byte;
      if (w_wr_en && r_addr >= 7'h10 && r_addr <= 7'h2F)
        r_sh_chr[r_addr[4:0] - 5'h10] <= spi.rx_byte;
      if (w_frame_end && !w_set_err) begin
        r_bars <= r_sh_bars;
        r_chr  <= r_sh_chr;
      end
    end
  end
`else
  assign w_src_bars = r_bars;
  assign w_src_chr  = r_chr;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_bars <= '0;
      r_chr  <= {32{BLANK_CHAR}};
    end else begin
      if (w_wr_en && r_addr < 7'h08)
        r_bars[r_addr[2:0]] <= spi.rx_byte;
      if (w_wr_en && r_addr >= 7'h10 && r_addr <= 7'h2F)
        r_chr[r_addr[4:0] - 5'h10] <= spi.rx_byte;
    end
  end
`endif

  // Char k (= 4*string + pos) lands with string 0 / char 0 in the top byte
  always_comb begin
    strs = '0;
    for (int k = 0; k < 32; k++) strs[8*(31-k) +: 8] = r_chr[k];
  end

  assign bars        = r_bars;
  assign frame_err   = r_err;
  assign spi.tx_byte = r_tx;

endmodule
